u_xmit_feed: RTL and testbench
==============================

# u_xmit_feed

Transmit feeder stage placed directly upstream of the UART transmitter. It buffers host bytes in a small synchronous FIFO and hands them one at a time to the transmitter through the `xmitH`/`xmit_dataH`/`xmit_doneH` handshake. It also reports FIFO occupancy, overflow and handshake errors to the host.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `ADDR_W`, default 3: log2(`DEPTH`).
- `BUSY_TO`, default 4: cycles allowed in F_WAIT_BUSY for `xmit_doneH` to fall.
- One clock; reset is asynchronous and active-low. Clock port: `sys_clk`. Reset port: `sys_rst_l`.
- `sys_clk` in 1: system clock, all state on rising edge.
- `sys_rst_l` in 1: asynchronous active-low reset.
- `wr_enH` in 1: host write strobe, one byte per cycle.
- `wr_dataH` in 8: host byte.
- `clr_errH` in 1: clears `overflowH` and `tx_errH`.
- `fullH` out 1: count == `DEPTH`.
- `emptyH` out 1: count == 0.
- `fifo_countH` out `ADDR_W`+1: current occupancy.
- `overflowH` out 1: sticky; a write was dropped.
- `tx_errH` out 1: sticky; the transmitter failed to go busy in time.
- `xmitH` out 1: one-cycle transmit request to the transmitter.
- `xmit_dataH` out 8: byte to the transmitter; registered and held until the next pop.
- `xmit_doneH` in 1: transmitter idle/done, high when idle.

## Operation
- FIFO: circular buffer with `ADDR_W`-bit read/write pointers that wrap naturally, plus an (`ADDR_W`+1)-bit count.
- Write is accepted iff `wr_enH` && (!`fullH` || pop this cycle).
- Write while full with no pop: byte dropped, `overflowH` set; pointers and count unchanged.
- Simultaneous accepted write and pop: count unchanged, both pointers advance. With the FIFO empty, a write does not bypass; it is popped on a later cycle.
- FSM states: F_IDLE, F_LOAD, F_WAIT_BUSY, F_WAIT_DONE.
  - F_IDLE: if !`emptyH` && `xmit_doneH`, then pop, `xmit_dataH` <= head byte, go to F_LOAD. Otherwise stay.
  - F_LOAD: `xmitH`=1 for exactly this cycle; go to F_WAIT_BUSY; clear the timeout counter.
  - F_WAIT_BUSY:
    - `xmit_doneH`==0: go to F_WAIT_DONE.
    - Otherwise increment the timeout counter. When it reaches `BUSY_TO`, set `tx_errH` and go to F_IDLE; the byte is lost.
  - F_WAIT_DONE: when `xmit_doneH`==1, go to F_IDLE.
- Illegal state encoding: go to F_IDLE.
- `clr_errH` with a same-cycle set event: set wins.
- Reset value of every output and register is 0: `xmitH`, `xmit_dataH`, pointers, count, flags and timeout counter; the FSM resets to F_IDLE. Derived outputs follow: `emptyH`=1, `fullH`=0.
- Reset mid-transfer discards FIFO contents and any in-flight handshake.

## Timing
- Pop decision at cycle N (F_IDLE) → `xmitH`=1 and `xmit_dataH` valid at N+1 → transmitter samples at the end of N+1.
- The transmitter's registered `xmit_doneH` falls at N+3. The minimum `BUSY_TO` that tolerates this is 2; the default is 4.
- Back-to-back bytes: next pop occurs in the first F_IDLE cycle after `xmit_doneH` returns high. Idle gap between transfers is 1 cycle (F_WAIT_DONE→F_IDLE→pop).
- `fifo_countH`, `fullH`, `emptyH` reflect the registered state and update one cycle after a write/pop edge.
- `xmitH` is a registered Moore output; it is never asserted for 2 consecutive cycles.

## Structure
- Shared constants go in the common include/package: FSM encodings (F_IDLE=0, F_LOAD=1, F_WAIT_BUSY=2, F_WAIT_DONE=3), HI/LO, default `DEPTH`.
- Sub-module `u_fifo_sync`: parameterised storage, pointers, count, full/empty and overflow detect. It is reusable on the receive side.
- `u_xmit_feed` contains the FSM, timeout counter, `xmit_dataH` register and error flags.

## Test plan
- Reset, then write 0x41 with `xmit_doneH`=1 and a model transmitter responding: `xmitH` pulses once with `xmit_dataH`=0x41 two cycles after the write; count returns 0.
- Write 0x01..0x08 back-to-back while the transmitter is busy: `fullH`=1, count=8. A 9th write of 0x09 sets `overflowH`; bytes are transmitted in order 0x01..0x08 and 0x09 is never sent.
- FIFO full and F_IDLE pop coincide with a write of 0xAA: write accepted, count stays 8, no overflow.
- Transmitter model holds `xmit_doneH`=1 after `xmitH`: `tx_errH` sets after 4 F_WAIT_BUSY cycles, FSM returns to F_IDLE, next byte is offered. `clr_errH` then clears the flag.
- Write 10 bytes across pointer wrap with interleaved pops: output sequence matches input; `emptyH`=1 at the end.
- Assert `sys_rst_l`=0 while in F_WAIT_DONE with 3 bytes queued: all outputs 0 and `emptyH`=1 immediately, with no `xmitH` after release until a new write.

Source files
------------

// File: rtl/u_xmit_feed_pkg.sv
// ---------------------------------------------------------------------------
// u_xmit_feed_pkg
// Shared constants for the transmit feeder and its FIFO.
//   feed_state_e : handshake FSM encoding (F_IDLE=0 .. F_WAIT_DONE=3)
//   HI / LO      : single-bit logic levels
//   DEFAULT_*    : default FIFO depth, pointer width and busy timeout
//   BYTE_W       : data width of the host / transmitter byte path
// ---------------------------------------------------------------------------
package u_xmit_feed_pkg;

  typedef enum logic [1:0] {
    F_IDLE      = 2'd0,
    F_LOAD      = 2'd1,
    F_WAIT_BUSY = 2'd2,
    F_WAIT_DONE = 2'd3
  } feed_state_e;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  localparam int DEFAULT_DEPTH   = 8;
  localparam int DEFAULT_ADDR_W  = 3;
  localparam int DEFAULT_BUSY_TO = 4;
  localparam int BYTE_W          = 8;

endpackage

// File: rtl/u_fifo_sync.sv
// ---------------------------------------------------------------------------
// u_fifo_sync
// Synchronous circular-buffer FIFO, reusable on transmit and receive sides.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en, wr_data  : write strobe and data
//   rd_en           : pop the head entry (ignored while empty)
//   rd_data         : head entry (combinational view of storage)
//   full, empty     : occupancy flags derived from the registered count
//   count           : registered occupancy, 0..DEPTH
//   wr_drop         : one-cycle pulse, a write was refused because full
// A write while full is still accepted when a pop happens the same cycle.
// ---------------------------------------------------------------------------
module u_fifo_sync
  import u_xmit_feed_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int W      = BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  output logic [W-1:0]      rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              wr_drop
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [W-1:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_acc;
  logic              rd_do;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign rd_do   = rd_en && !empty;
  assign wr_acc  = wr_en && (!full || rd_do);
  assign wr_drop = wr_en && full && !rd_do;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are ADDR_W wide and wrap naturally at DEPTH.
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_do)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_do})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/u_xmit_feed.sv
// ---------------------------------------------------------------------------
// u_xmit_feed
// Transmit feeder: buffers host bytes and hands them one at a time to the
// UART transmitter.
// Ports:
//   sys_clk, sys_rst_l     : clock, asynchronous active-low reset
//   wr_enH, wr_dataH       : host write strobe / byte
//   clr_errH               : clears overflowH and tx_errH (a same-cycle set wins)
//   fullH, emptyH          : FIFO occupancy flags
//   fifo_countH            : FIFO occupancy
//   overflowH              : sticky, a host write was dropped
//   tx_errH                : sticky, transmitter failed to go busy in time
//   xmitH, xmit_dataH      : one-cycle request and held byte to the transmitter
//   xmit_doneH             : transmitter idle (high) / busy (low)
//   dbg_stateH             : current FSM state, for observation only
// Handshake: a byte is offered by pulsing xmitH for exactly one cycle with
// xmit_dataH valid; the transmitter acknowledges by dropping xmit_doneH
// within BUSY_TO cycles and signals completion by raising it again. The next
// pop happens only in F_IDLE with xmit_doneH high.
// ---------------------------------------------------------------------------
module u_xmit_feed
  import u_xmit_feed_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int BUSY_TO = DEFAULT_BUSY_TO
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic              wr_enH,
  input  logic [BYTE_W-1:0] wr_dataH,
  input  logic              clr_errH,
  output logic              fullH,
  output logic              emptyH,
  output logic [ADDR_W:0]   fifo_countH,
  output logic              overflowH,
  output logic              tx_errH,
  output logic              xmitH,
  output logic [BYTE_W-1:0] xmit_dataH,
  input  logic              xmit_doneH,
  output logic [1:0]        dbg_stateH
);

  localparam int              TO_W     = $clog2(BUSY_TO + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(BUSY_TO);

  feed_state_e       state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              xmit_q, xmit_d;
  logic [BYTE_W-1:0] xmit_data_q, xmit_data_d;
  logic              overflow_q, overflow_d;
  logic              tx_err_q, tx_err_d;

  logic              pop;
  logic              to_set;
  logic [BYTE_W-1:0] fifo_head;
  logic              fifo_drop;

  u_fifo_sync #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (BYTE_W)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_l),
    .wr_en   (wr_enH),
    .wr_data (wr_dataH),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fullH),
    .empty   (emptyH),
    .count   (fifo_countH),
    .wr_drop (fifo_drop)
  );

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    xmit_data_d = xmit_data_q;
    pop         = LO;
    to_set      = LO;
    case (state_q)
      F_IDLE: begin
        if (!emptyH && xmit_doneH) begin
          pop         = HI;
          xmit_data_d = fifo_head;
          state_d     = F_LOAD;
        end
      end
      F_LOAD: begin
        to_cnt_d = '0;
        state_d  = F_WAIT_BUSY;
      end
      F_WAIT_BUSY: begin
        if (!xmit_doneH) begin
          state_d = F_WAIT_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          // Transmitter never went busy: the offered byte is abandoned.
          if (to_cnt_d == TO_LIMIT) begin
            to_set  = HI;
            state_d = F_IDLE;
          end
        end
      end
      F_WAIT_DONE: begin
        if (xmit_doneH) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
    // Registered Moore request: high exactly while the FSM sits in F_LOAD.
    xmit_d = (state_d == F_LOAD);
  end

  // Sticky flags: a set event in the same cycle as clr_errH takes priority.
  always_comb begin
    overflow_d = overflow_q;
    tx_err_d   = tx_err_q;
    if (clr_errH) begin
      overflow_d = LO;
      tx_err_d   = LO;
    end
    if (fifo_drop) overflow_d = HI;
    if (to_set)    tx_err_d   = HI;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q     <= F_IDLE;
      to_cnt_q    <= '0;
      xmit_q      <= LO;
      xmit_data_q <= '0;
      overflow_q  <= LO;
      tx_err_q    <= LO;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      xmit_q      <= xmit_d;
      xmit_data_q <= xmit_data_d;
      overflow_q  <= overflow_d;
      tx_err_q    <= tx_err_d;
    end
  end

  assign xmitH      = xmit_q;
  assign xmit_dataH = xmit_data_q;
  assign overflowH  = overflow_q;
  assign tx_errH    = tx_err_q;
  assign dbg_stateH = state_q;

endmodule

// File: tb/tb_u_xmit_feed.sv
// ---------------------------------------------------------------------------
// tb_u_xmit_feed
// Directed bench for u_xmit_feed with a behavioural UART transmitter model
// and an expected-byte queue checked on every xmitH pulse.
// ---------------------------------------------------------------------------
module tb_u_xmit_feed;
  import u_xmit_feed_pkg::*;

  localparam int TX_LEN = 3;

  // ---------------- clock / reset ----------------
  logic       sys_clk = 1'b0;
  logic       sys_rst_l = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       wr_enH = 1'b0;
  logic [7:0] wr_dataH = 8'h00;
  logic       clr_errH = 1'b0;
  logic       fullH, emptyH, overflowH, tx_errH, xmitH;
  logic [3:0] fifo_countH;
  logic [7:0] xmit_dataH;
  logic       xmit_doneH;
  logic [1:0] dbg_stateH;

  u_xmit_feed dut (
    .sys_clk     (sys_clk),
    .sys_rst_l   (sys_rst_l),
    .wr_enH      (wr_enH),
    .wr_dataH    (wr_dataH),
    .clr_errH    (clr_errH),
    .fullH       (fullH),
    .emptyH      (emptyH),
    .fifo_countH (fifo_countH),
    .overflowH   (overflowH),
    .tx_errH     (tx_errH),
    .xmitH       (xmitH),
    .xmit_dataH  (xmit_dataH),
    .xmit_doneH  (xmit_doneH),
    .dbg_stateH  (dbg_stateH)
  );

  // ---------------- scoreboard state ----------------
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  int         xmit_seen = 0;
  logic       prev_xmit = 1'b0;
  logic       seen_xmit = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- transmitter model ----------------
  // model_hold keeps the transmitter busy; model_stuck ignores requests.
  logic model_hold = 1'b0;
  logic model_stuck = 1'b0;
  logic pend;
  int   busy_cnt;

  always @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      pend       <= 1'b0;
      busy_cnt   <= 0;
      xmit_doneH <= 1'b1;
    end else begin
      pend <= seen_xmit && !model_stuck;
      if (pend) begin
        xmit_doneH <= 1'b0;
        busy_cnt   <= TX_LEN;
      end else if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end else begin
        busy_cnt   <= 0;
        xmit_doneH <= !model_hold;
      end
    end
  end

  // Monitor: every request must carry the next expected byte, never two in a row.
  always @(negedge sys_clk) begin
    if (!sys_rst_l) begin
      prev_xmit = 1'b0;
      seen_xmit = 1'b0;
    end else begin
      if (xmitH) begin
        xmit_seen++;
        if (prev_xmit) check("xmit_b2b", 32'(1), 32'(0));
        if (exp_q.size() == 0) check("xmit_unexpected", 32'(xmit_dataH), 32'hFFFF);
        else check("xmit_data", 32'(xmit_dataH), 32'(exp_q.pop_front()));
      end
      prev_xmit = xmitH;
      seen_xmit = xmitH;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_write(input logic [7:0] d);
    wr_enH   = 1'b1;
    wr_dataH = d;
    @(negedge sys_clk);
    wr_enH   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(dbg_stateH == F_IDLE && emptyH && xmit_doneH) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 32'(n), 32'(0));
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
    int n = 0;
    while (dbg_stateH != st && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 32'(n), 32'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int xs;
    repeat (3) @(negedge sys_clk);
    check("rst_empty", 32'(emptyH), 32'(1));
    check("rst_count", 32'(fifo_countH), 32'(0));
    sys_rst_l = 1'b1;
    @(negedge sys_clk);
    check("rst_xmit", 32'(xmitH), 32'(0));
    check("rst_xdata", 32'(xmit_dataH), 32'(0));
    check("rst_full", 32'(fullH), 32'(0));
    check("rst_flags", 32'({overflowH, tx_errH}), 32'(0));
    check("rst_state", 32'(dbg_stateH), 32'(F_IDLE));

    // Single byte: request two cycles after the write.
    exp_q.push_back(8'h41);
    do_write(8'h41);
    check("t1_xmit_early", 32'(xmitH), 32'(0));
    check("t1_count1", 32'(fifo_countH), 32'(1));
    @(negedge sys_clk);
    check("t1_xmit", 32'(xmitH), 32'(1));
    check("t1_count0", 32'(fifo_countH), 32'(0));
    wait_idle(50, "t1");

    // Fill while the transmitter is busy, then overflow.
    model_hold = 1'b1;
    @(negedge sys_clk);
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      do_write(8'(i));
    end
    check("t2_full", 32'(fullH), 32'(1));
    check("t2_count", 32'(fifo_countH), 32'(8));
    check("t2_no_ovf", 32'(overflowH), 32'(0));
    wr_enH = 1'b1; wr_dataH = 8'h09; clr_errH = 1'b1;
    @(negedge sys_clk);
    wr_enH = 1'b0; clr_errH = 1'b0;
    check("t2_ovf_set_wins", 32'(overflowH), 32'(1));
    check("t2_count_kept", 32'(fifo_countH), 32'(8));
    clr_errH = 1'b1;
    @(negedge sys_clk);
    clr_errH = 1'b0;
    check("t2_ovf_clr", 32'(overflowH), 32'(0));

    // Release: first pop coincides with a write while full.
    model_hold = 1'b0;
    @(negedge sys_clk);
    check("t3_done_hi", 32'(xmit_doneH), 32'(1));
    exp_q.push_back(8'hAA);
    do_write(8'hAA);
    check("t3_count", 32'(fifo_countH), 32'(8));
    check("t3_no_ovf", 32'(overflowH), 32'(0));
    check("t3_xmit", 32'(xmitH), 32'(1));
    wait_idle(300, "t3");
    check("t3_drained", 32'(exp_q.size()), 32'(0));

    // Transmitter never goes busy: timeout after BUSY_TO cycles.
    model_stuck = 1'b1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    do_write(8'h55);
    do_write(8'h66);
    check("t4_load", 32'(dbg_stateH), 32'(F_LOAD));
    repeat (4) @(negedge sys_clk);
    check("t4_still_busy_wait", 32'(dbg_stateH), 32'(F_WAIT_BUSY));
    check("t4_no_err_yet", 32'(tx_errH), 32'(0));
    @(negedge sys_clk);
    check("t4_err", 32'(tx_errH), 32'(1));
    check("t4_idle", 32'(dbg_stateH), 32'(F_IDLE));
    model_stuck = 1'b0;
    @(negedge sys_clk);
    check("t4_next_offered", 32'(xmitH), 32'(1));
    wait_idle(50, "t4");
    check("t4_err_sticky", 32'(tx_errH), 32'(1));
    clr_errH = 1'b1;
    @(negedge sys_clk);
    clr_errH = 1'b0;
    check("t4_err_clr", 32'(tx_errH), 32'(0));

    // Ten bytes across pointer wrap with pops interleaved.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'hB0 + 8'(i));
      do_write(8'hB0 + 8'(i));
      repeat (2) @(negedge sys_clk);
    end
    wait_idle(300, "t5");
    check("t5_empty", 32'(emptyH), 32'(1));
    check("t5_count", 32'(fifo_countH), 32'(0));
    check("t5_no_ovf", 32'(overflowH), 32'(0));
    check("t5_drained", 32'(exp_q.size()), 32'(0));

    // Reset in F_WAIT_DONE with three bytes queued.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      do_write(8'hC0 + 8'(i));
    end
    wait_state(F_WAIT_DONE, 20, "t6");
    check("t6_state", 32'(dbg_stateH), 32'(F_WAIT_DONE));
    check("t6_count", 32'(fifo_countH), 32'(3));
    sys_rst_l = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_empty", 32'(emptyH), 32'(1));
    check("t6_rst_count", 32'(fifo_countH), 32'(0));
    check("t6_rst_outs", 32'({xmitH, xmit_dataH, fullH, overflowH, tx_errH}), 32'(0));
    check("t6_rst_state", 32'(dbg_stateH), 32'(F_IDLE));
    @(negedge sys_clk);
    sys_rst_l = 1'b1;
    xs = xmit_seen;
    repeat (20) @(negedge sys_clk);
    check("t6_no_xmit", 32'(xmit_seen), 32'(xs));
    exp_q.push_back(8'h5A);
    do_write(8'h5A);
    wait_idle(50, "t6b");
    check("t6_new_xmit", 32'(xmit_seen), 32'(xs + 1));
    check("final_exp_q", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
